// File: rtl/ascon_sequencer.sv
// Control FSM for the ASCON-128 encryption datapath: sequences init p12, one AD block,
// NB_PT_BLOCKS plaintext blocks and finalisation p12, driving muxes, enables and round-counter loads.
module ascon_sequencer #(
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [3:0] round_i,
  output logic       data_ready_o,
  output logic       input_select_o,
  output logic       xorup_select_o,
  output logic [1:0] xordn_select_o,
  output logic       ena_reg_o,
  output logic       ena_rc_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       final_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       done_o
);

  localparam int CW = $clog2(NB_PT_BLOCKS + 1);
  localparam logic [CW-1:0] LAST_BLK = CW'(NB_PT_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   blk_cnt_reg;

  logic r0, r6, r11;
  logic last_blk, next_is_last;

  assign r0  = (round_i == 4'd0);
  assign r6  = (round_i == 4'd6);
  assign r11 = (round_i == 4'd11);

  // last_blk: the block about to be (or being) accepted is the final plaintext block
  assign last_blk     = (blk_cnt_reg == LAST_BLK);
  assign next_is_last = ((blk_cnt_reg + 1'b1) == LAST_BLK);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_reg   <= IDLE;
      blk_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE:    if (start_i) state_reg <= INIT;
        INIT:    if (r11) state_reg <= WAIT_AD;
        WAIT_AD: if (data_valid_i) state_reg <= AD;
        AD:      if (r11) state_reg <= WAIT_PT;
        WAIT_PT: if (data_valid_i) state_reg <= last_blk ? FINAL : PT;
        PT: begin
          if (r11) begin
            state_reg   <= WAIT_PT;
            blk_cnt_reg <= blk_cnt_reg + 1'b1;
          end
        end
        FINAL:   if (r11) state_reg <= DONE;
        DONE: begin
          state_reg   <= IDLE;
          blk_cnt_reg <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state plus the counter's round index.
  // Counter loads are always requested one cycle ahead of the phase they prepare.
  always_comb begin
    data_ready_o   = 1'b0;
    input_select_o = 1'b0;
    xorup_select_o = 1'b0;
    xordn_select_o = 2'b00;
    ena_reg_o      = 1'b0;
    ena_rc_o       = 1'b0;
    init_a_o       = 1'b0;
    init_b_o       = 1'b0;
    final_o        = 1'b0;
    cipher_valid_o = 1'b0;
    tag_valid_o    = 1'b0;
    done_o         = 1'b0;
    case (state_reg)
      IDLE: begin
        init_a_o = 1'b1;
        ena_rc_o = 1'b1;
      end
      INIT: begin
        ena_reg_o      = 1'b1;
        ena_rc_o       = 1'b1;
        input_select_o = !r0;
        if (r11) begin
          xordn_select_o = 2'b01;
          init_b_o       = 1'b1;
        end
      end
      WAIT_AD: begin
        data_ready_o = 1'b1;
        init_b_o     = 1'b1;
      end
      AD: begin
        input_select_o = 1'b1;
        ena_reg_o      = 1'b1;
        ena_rc_o       = 1'b1;
        xorup_select_o = r6;
        if (r11) begin
          xordn_select_o = 2'b10;
          init_a_o       = last_blk;
          init_b_o       = !last_blk;
        end
      end
      WAIT_PT: begin
        data_ready_o = 1'b1;
        init_a_o     = last_blk;
        init_b_o     = !last_blk;
      end
      PT: begin
        input_select_o = 1'b1;
        ena_reg_o      = 1'b1;
        ena_rc_o       = 1'b1;
        xorup_select_o = r6;
        cipher_valid_o = r6;
        if (r11) begin
          init_a_o = next_is_last;
          init_b_o = !next_is_last;
        end
      end
      FINAL: begin
        final_o        = 1'b1;
        ena_reg_o      = 1'b1;
        ena_rc_o       = 1'b1;
        input_select_o = 1'b1;
        xorup_select_o = r0;
        cipher_valid_o = r0;
        if (r11) xordn_select_o = 2'b01;
      end
      DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        init_a_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_sequencer.sv
// Bench for ascon_sequencer: one instance with 4 plaintext blocks, one with a single block,
// each driven by a round-counter model and checked against a phase-level message model.
module tb_ascon_sequencer;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [1:0] start_s = '0;
  logic [1:0] valid_s = '0;
  logic [3:0] round_s [2];
  logic [1:0] dr, isel, xup, ereg, erc, ia, ib, fin, cv, tv, dn;
  logic [1:0] xdn_s [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ascon_sequencer #(.NB_PT_BLOCKS(gi == 0 ? 4 : 1)) u_dut (
      .clock_i(clk), .resetb_i(resetb), .start_i(start_s[gi]), .data_valid_i(valid_s[gi]),
      .round_i(round_s[gi]), .data_ready_o(dr[gi]), .input_select_o(isel[gi]),
      .xorup_select_o(xup[gi]), .xordn_select_o(xdn_s[gi]), .ena_reg_o(ereg[gi]),
      .ena_rc_o(erc[gi]), .init_a_o(ia[gi]), .init_b_o(ib[gi]), .final_o(fin[gi]),
      .cipher_valid_o(cv[gi]), .tag_valid_o(tv[gi]), .done_o(dn[gi])
    );
  end

  // Round counter with synchronous loads taking priority over increment
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      round_s[0] <= 4'd0;
      round_s[1] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ia[i])       round_s[i] <= 4'd0;
        else if (ib[i])  round_s[i] <= 4'd6;
        else if (erc[i]) round_s[i] <= round_s[i] + 4'd1;
      end
    end
  end

  int cyc = 0;
  int n_cv [2] = '{0, 0};
  int n_tv [2] = '{0, 0};
  int n_dm [2] = '{0, 0};
  int t_done [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cv[i]) n_cv[i] <= n_cv[i] + 1;
      if (tv[i]) n_tv[i] <= n_tv[i] + 1;
      if (xdn_s[i] == 2'b10) n_dm[i] <= n_dm[i] + 1;
      if (dn[i]) t_done[i] <= cyc;
    end
  end

  typedef struct {
    bit          start;
    bit          valid;
    logic [12:0] exp;
    int          rnd;
    int          mark;
    string       ph;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int fails  = 0;

  // Output vector order: dr isel xup xdn[1:0] ereg erc ia ib fin cv tv done
  function automatic logic [12:0] ev(bit d_r, bit i_s, bit x_u, logic [1:0] x_d, bit e_r,
                                     bit e_c, bit i_a, bit i_b, bit f_n, bit c_v, bit t_v, bit d_n);
    return {d_r, i_s, x_u, x_d, e_r, e_c, i_a, i_b, f_n, c_v, t_v, d_n};
  endfunction

  function automatic logic [12:0] act(int d);
    return {dr[d], isel[d], xup[d], xdn_s[d], ereg[d], erc[d], ia[d], ib[d], fin[d], cv[d], tv[d], dn[d]};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, a, e);
    end
  endtask

  task automatic push(input bit s, input bit v, input logic [12:0] e, input int r, input int m, input string p);
    vec_t x;
    x.start = s; x.valid = v; x.exp = e; x.rnd = r; x.mark = m; x.ph = p;
    tbl.push_back(x);
  endtask

  task automatic wait_ph(input int s, input logic [12:0] e, input int r, input bit rs, input string p);
    for (int k = 0; k < s; k++) push(rs ? rb() : 1'b0, 1'b0, e, r, 0, p);
    push(rs ? rb() : 1'b0, 1'b1, e, r, 0, p);
  endtask

  // Message model. mode 0: valid held high, start pulsed; mode 1: 5-cycle stall on the first
  // plaintext block with start high during AD/DONE; mode 2: random stalls and ignored inputs.
  task automatic build(input int nb, input int mode, output int lat);
    bit rs;
    bit last, nl;
    int s;
    rs  = (mode == 2);
    lat = 0;
    push(1'b1, rs ? rb() : 1'b1, ev(0,0,0,2'b00,0,1,1,0,0,0,0,0), 0, 0, "idle");
    for (int r = 0; r < 12; r++) begin
      push(rs ? rb() : 1'b0, rs ? rb() : 1'b1,
           ev(0, r != 0, 0, (r == 11) ? 2'b01 : 2'b00, 1, 1, 0, r == 11, 0, 0, 0, 0),
           r, (r == 0) ? 1 : 0, "init");
      lat++;
    end
    s = rs ? int'($urandom_range(0, 3)) : 0;
    wait_ph(s, ev(1,0,0,2'b00,0,0,0,1,0,0,0,0), 6, rs, "wait_ad");
    lat += s + 1;
    for (int r = 6; r < 12; r++) begin
      push(rs ? rb() : (mode == 1), rs ? rb() : 1'b1,
           ev(0, 1, r == 6, (r == 11) ? 2'b10 : 2'b00, 1, 1, (r == 11) && (nb == 1),
              (r == 11) && (nb != 1), 0, 0, 0, 0), r, 0, "ad");
      lat++;
    end
    for (int b = 0; b < nb; b++) begin
      last = (b == nb - 1);
      s = rs ? int'($urandom_range(0, 3)) : ((mode == 1 && b == 0) ? 5 : 0);
      wait_ph(s, ev(1,0,0,2'b00,0,0,last,!last,0,0,0,0), last ? 0 : 6, rs, "wait_pt");
      lat += s + 1;
      if (!last) begin
        nl = (b + 1 == nb - 1);
        for (int r = 6; r < 12; r++) begin
          push(rs ? rb() : 1'b0, rs ? rb() : 1'b1,
               ev(0, 1, r == 6, 2'b00, 1, 1, (r == 11) && nl, (r == 11) && !nl, 0, r == 6, 0, 0),
               r, 0, "pt");
          lat++;
        end
      end
    end
    for (int r = 0; r < 12; r++) begin
      push(rs ? rb() : 1'b0, rs ? rb() : 1'b1,
           ev(0, 1, r == 0, (r == 11) ? 2'b01 : 2'b00, 1, 1, 0, 0, 1, r == 0, 0, 0), r, 0, "final");
      lat++;
    end
    push(rs ? rb() : (mode == 1), rs ? rb() : 1'b1, ev(0,0,0,2'b00,0,0,1,0,0,0,1,1), -1, 2, "done");
    push(1'b0, rs ? rb() : 1'b1, ev(0,0,0,2'b00,0,1,1,0,0,0,0,0), 0, 0, "idle_end");
    push(1'b0, rs ? rb() : 1'b1, ev(0,0,0,2'b00,0,1,1,0,0,0,0,0), 0, 0, "idle_end");
  endtask

  task automatic apply(input int d, input int lo, input int hi, output int t0);
    t0 = -1;
    for (int i = lo; i <= hi; i++) begin
      start_s[d] = tbl[i].start;
      valid_s[d] = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("dut%0d %s[%0d] outputs", d, tbl[i].ph, i), int'(act(d)), int'(tbl[i].exp));
      if (tbl[i].rnd >= 0)
        chk($sformatf("dut%0d %s[%0d] round", d, tbl[i].ph, i), int'(round_s[d]), tbl[i].rnd);
      if (tbl[i].mark == 1) t0 = cyc;
      @(posedge clk); #1;
    end
    start_s[d] = 1'b0;
    valid_s[d] = 1'b0;
  endtask

  task automatic run_msg(input int d, input int nb, input int mode);
    int lat, t0, cv0, tv0, dm0;
    tbl.delete();
    build(nb, mode, lat);
    cv0 = n_cv[d]; tv0 = n_tv[d]; dm0 = n_dm[d];
    apply(d, 0, tbl.size() - 1, t0);
    chk($sformatf("dut%0d mode%0d done latency", d, mode), t_done[d] - t0, lat);
    chk($sformatf("dut%0d mode%0d cipher pulses", d, mode), n_cv[d] - cv0, nb);
    chk($sformatf("dut%0d mode%0d tag pulses", d, mode), n_tv[d] - tv0, 1);
    chk($sformatf("dut%0d mode%0d domain xor", d, mode), n_dm[d] - dm0, 1);
    $display("msg dut%0d nb=%0d mode=%0d cycles=%0d", d, nb, mode, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    // Reset state: init_a_o high, ena_rc_o excluded (IDLE decode), everything else low
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("dut%0d reset outputs", d), int'(act(d) & 13'h1fbf), int'(ev(0,0,0,2'b00,0,0,1,0,0,0,0,0)));
    #2 resetb = 1'b1;
    @(posedge clk); #1;

    run_msg(0, 4, 0);
    run_msg(0, 4, 1);
    run_msg(1, 1, 0);
    for (int k = 0; k < 3; k++) run_msg(1, 1, 2);
    for (int k = 0; k < 6; k++) run_msg(0, 4, 2);

    // Reset in the middle of a plaintext block
    tbl.delete();
    build(4, 0, t0);
    apply(0, 0, 23, t0);
    #2 resetb = 1'b0;
    #1 chk("midpt reset outputs", int'(act(0) & 13'h1fbf), int'(ev(0,0,0,2'b00,0,0,1,0,0,0,0,0)));
    @(negedge clk);
    #2 resetb = 1'b1;
    valid_s[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post reset idle", int'(act(0)), int'(ev(0,0,0,2'b00,0,1,1,0,0,0,0,0)));
    end
    @(posedge clk); #1;
    valid_s[0] = 1'b0;
    run_msg(0, 4, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
